// File: rtl/mem_arbiter.sv
// Arbiter sharing one block-wide memory port between an instruction cache and a
// data cache; round-robin on ties, with a data-cache writeback-then-fill sequence.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int BLK_W  = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [BLK_W-1:0]  i_rdata,
  output logic              i_valid,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] d_waddr,
  input  logic [BLK_W-1:0]  d_wdata,
  output logic [BLK_W-1:0]  d_rdata,
  output logic              d_valid,
  output logic              d_wdone,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_read_addr,
  output logic [ADDR_W-1:0] m_write_addr,
  output logic [BLK_W-1:0]  m_write_data,
  input  logic [BLK_W-1:0]  m_read_data,
  input  logic              m_read_valid,
  input  logic              m_write_done,
  output logic [1:0]        grant
);

  typedef enum logic [2:0] {
    S_IDLE, S_I_FILL, S_D_WB, S_D_FILL, S_RECOVER
  } state_e;

  typedef enum logic {OWN_I, OWN_D} owner_e;

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_I    = 2'b01;
  localparam logic [1:0] G_D    = 2'b10;

  function automatic logic [ADDR_W-1:0] blk_align(input logic [ADDR_W-1:0] a);
    return a & ~{{(ADDR_W-4){1'b0}}, 4'hF};
  endfunction

  state_e            state_q, state_d;
  owner_e            last_owner_q, last_owner_d;
  logic              m_read_q, m_read_d;
  logic              m_write_q, m_write_d;
  logic [ADDR_W-1:0] m_read_addr_q, m_read_addr_d;
  logic [ADDR_W-1:0] m_write_addr_q, m_write_addr_d;
  logic [BLK_W-1:0]  m_write_data_q, m_write_data_d;
  logic [1:0]        grant_q, grant_d;
  logic              i_valid_q, i_valid_d;
  logic              d_valid_q, d_valid_d;
  logic              d_wdone_q, d_wdone_d;
  logic [BLK_W-1:0]  i_rdata_q, i_rdata_d;
  logic [BLK_W-1:0]  d_rdata_q, d_rdata_d;

  logic d_req;
  logic pick_i;

  assign d_req  = d_read | d_write;
  // Icache wins when alone, or on a tie when the dcache was served last.
  assign pick_i = i_read && (!d_req || last_owner_q == OWN_D);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d        = state_q;
    last_owner_d   = last_owner_q;
    m_read_d       = m_read_q;
    m_write_d      = m_write_q;
    m_read_addr_d  = m_read_addr_q;
    m_write_addr_d = m_write_addr_q;
    m_write_data_d = m_write_data_q;
    grant_d        = grant_q;
    i_valid_d      = 1'b0;
    d_valid_d      = 1'b0;
    d_wdone_d      = 1'b0;
    i_rdata_d      = i_rdata_q;
    d_rdata_d      = d_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (pick_i) begin
          state_d       = S_I_FILL;
          last_owner_d  = OWN_I;
          grant_d       = G_I;
          m_read_d      = 1'b1;
          m_read_addr_d = blk_align(i_addr);
        end else if (d_req) begin
          last_owner_d = OWN_D;
          grant_d      = G_D;
          if (d_write) begin
            state_d        = S_D_WB;
            m_write_d      = 1'b1;
            m_write_addr_d = blk_align(d_waddr);
            m_write_data_d = d_wdata;
          end else begin
            state_d       = S_D_FILL;
            m_read_d      = 1'b1;
            m_read_addr_d = blk_align(d_addr);
          end
        end
      end

      S_I_FILL: begin
        if (m_read_valid) begin
          state_d   = S_RECOVER;
          m_read_d  = 1'b0;
          grant_d   = G_NONE;
          i_rdata_d = m_read_data;
          i_valid_d = 1'b1;
        end
      end

      S_D_WB: begin
        if (m_write_done) begin
          m_write_d = 1'b0;
          d_wdone_d = 1'b1;
          // Fill follows the writeback directly, keeping the dcache grant.
          if (d_read) begin
            state_d       = S_D_FILL;
            m_read_d      = 1'b1;
            m_read_addr_d = blk_align(d_addr);
          end else begin
            state_d = S_RECOVER;
            grant_d = G_NONE;
          end
        end
      end

      S_D_FILL: begin
        if (m_read_valid) begin
          state_d   = S_RECOVER;
          m_read_d  = 1'b0;
          grant_d   = G_NONE;
          d_rdata_d = m_read_data;
          d_valid_d = 1'b1;
        end
      end

      S_RECOVER: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: the block registers are reset too, since i_rdata/d_rdata must read 0 after reset.
    if (reset) begin
      state_q        <= S_IDLE;
      last_owner_q   <= OWN_D;
      m_read_q       <= 1'b0;
      m_write_q      <= 1'b0;
      m_read_addr_q  <= '0;
      m_write_addr_q <= '0;
      m_write_data_q <= '0;
      grant_q        <= G_NONE;
      i_valid_q      <= 1'b0;
      d_valid_q      <= 1'b0;
      d_wdone_q      <= 1'b0;
      i_rdata_q      <= '0;
      d_rdata_q      <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q        <= state_d;
      last_owner_q   <= last_owner_d;
      m_read_q       <= m_read_d;
      m_write_q      <= m_write_d;
      m_read_addr_q  <= m_read_addr_d;
      m_write_addr_q <= m_write_addr_d;
      m_write_data_q <= m_write_data_d;
      grant_q        <= grant_d;
      i_valid_q      <= i_valid_d;
      d_valid_q      <= d_valid_d;
      d_wdone_q      <= d_wdone_d;
      i_rdata_q      <= i_rdata_d;
      d_rdata_q      <= d_rdata_d;
    end
  end

  assign m_read       = m_read_q;
  assign m_write      = m_write_q;
  assign m_read_addr  = m_read_addr_q;
  assign m_write_addr = m_write_addr_q;
  assign m_write_data = m_write_data_q;
  assign grant        = grant_q;
  assign i_valid      = i_valid_q;
  assign d_valid      = d_valid_q;
  assign d_wdone      = d_wdone_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural memory checks addresses and
// returns queued blocks; a monitor compares every response pulse against the queues.
module tb_mem_arbiter;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
  } xact_t;

  logic         clock, reset;
  logic         i_read, d_read, d_write;
  logic [31:0]  i_addr, d_addr, d_waddr;
  logic [127:0] d_wdata, i_rdata, d_rdata, m_write_data, m_read_data;
  logic         i_valid, d_valid, d_wdone;
  logic         m_read, m_write, m_read_valid, m_write_done;
  logic [31:0]  m_read_addr, m_write_addr;
  logic [1:0]   grant;

  mem_arbiter #(.ADDR_W(32), .BLK_W(128)) dut (
    .clock(clock), .reset(reset),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_waddr(d_waddr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid), .d_wdone(d_wdone),
    .m_read(m_read), .m_write(m_write), .m_read_addr(m_read_addr),
    .m_write_addr(m_write_addr), .m_write_data(m_write_data),
    .m_read_data(m_read_data), .m_read_valid(m_read_valid),
    .m_write_done(m_write_done), .grant(grant)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int check_cnt = 0;
  int fail_cnt  = 0;
  int i_pulses = 0, d_pulses = 0, wd_pulses = 0, overlap_cnt = 0;
  int ip0, dp0, wp0;
  int rd_lat = 3, wr_lat = 3;

  xact_t        rd_q[$];
  xact_t        wr_q[$];
  logic [127:0] i_exp[$];
  logic [127:0] d_exp[$];
  logic [1:0]   grant_log[$];
  logic [1:0]   last_grant = 2'bxx;
  int           op_log[$];
  logic [1:0]   eg[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    check_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic exp_rd(input logic [31:0] addr, input logic [127:0] data, input bit is_i);
    rd_q.push_back('{addr & ~32'hF, data});
    if (is_i) i_exp.push_back(data);
    else      d_exp.push_back(data);
  endtask

  task automatic check_grants(input string tag, input logic [1:0] exp[$]);
    check({tag, "_len"}, grant_log.size(), exp.size());
    for (int k = 0; k < exp.size() && k < grant_log.size(); k++)
      check(tag, grant_log[k], exp[k]);
  endtask

  // sel: 0 i_valid, 1 d_valid, 2 d_wdone, 3 m_read
  task automatic wait_sig(input int sel, input string tag);
    int t = 0;
    bit seen = 1'b0;
    while (!seen && t < 300) begin
      @(negedge clock);
      t++;
      case (sel)
        0:       seen = (i_valid === 1'b1);
        1:       seen = (d_valid === 1'b1);
        2:       seen = (d_wdone === 1'b1);
        default: seen = (m_read === 1'b1);
      endcase
    end
    check(tag, seen, 1'b1);
  endtask

  task automatic run_i(input logic [31:0] a0, input int n);
    i_read = 1'b1;
    for (int k = 0; k < n; k++) begin
      i_addr = a0 + 32'(k * 16) + 32'h4;
      wait_sig(0, "i_valid_seen");
    end
    i_read = 1'b0;
  endtask

  task automatic run_dr(input logic [31:0] a0, input int n);
    d_read = 1'b1;
    for (int k = 0; k < n; k++) begin
      d_addr = a0 + 32'(k * 16) + 32'h8;
      wait_sig(1, "d_valid_seen");
    end
    d_read = 1'b0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    i_read  = 1'b0;
    d_read  = 1'b0;
    d_write = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic snap();
    ip0 = i_pulses;
    dp0 = d_pulses;
    wp0 = wd_pulses;
    grant_log.delete();
  endtask

  // Monitor: response pulses are scored against the expectation queues.
  always @(negedge clock) begin
    if (m_read === 1'b1 && m_write === 1'b1) overlap_cnt++;
    if (grant !== last_grant) begin
      grant_log.push_back(grant);
      last_grant = grant;
    end
    if (i_valid === 1'b1) begin
      i_pulses++;
      check("i_exp_avail", i_exp.size() > 0, 1'b1);
      if (i_exp.size() > 0) check("i_rdata", i_rdata, i_exp.pop_front());
    end
    if (d_valid === 1'b1) begin
      d_pulses++;
      check("d_exp_avail", d_exp.size() > 0, 1'b1);
      if (d_exp.size() > 0) check("d_rdata", d_rdata, d_exp.pop_front());
    end
    if (d_wdone === 1'b1) wd_pulses++;
  end

  // Memory read port: fixed latency, aborts quietly if m_read drops (reset).
  initial begin : mem_rd
    xact_t e;
    bit    ok;
    m_read_valid = 1'b0;
    m_read_data  = '0;
    forever begin
      @(negedge clock);
      if (m_read === 1'b1 && !reset) begin
        check("rd_expected", rd_q.size() > 0, 1'b1);
        e  = (rd_q.size() > 0) ? rd_q.pop_front() : '{32'hx, 128'h0};
        ok = 1'b1;
        for (int k = 1; k < rd_lat; k++) begin
          @(negedge clock);
          if (m_read !== 1'b1) begin
            ok = 1'b0;
            break;
          end
        end
        if (ok) begin
          check("m_read_addr", m_read_addr, e.addr);
          m_read_data  = e.data;
          m_read_valid = 1'b1;
          @(negedge clock);
          m_read_valid = 1'b0;
          op_log.push_back(2);
        end
      end
    end
  end

  initial begin : mem_wr
    xact_t e;
    bit    ok;
    m_write_done = 1'b0;
    forever begin
      @(negedge clock);
      if (m_write === 1'b1 && !reset) begin
        check("wr_expected", wr_q.size() > 0, 1'b1);
        e  = (wr_q.size() > 0) ? wr_q.pop_front() : '{32'hx, 128'hx};
        ok = 1'b1;
        for (int k = 1; k < wr_lat; k++) begin
          @(negedge clock);
          if (m_write !== 1'b1) begin
            ok = 1'b0;
            break;
          end
        end
        if (ok) begin
          check("m_write_addr", m_write_addr, e.addr);
          check("m_write_data", m_write_data, e.data);
          m_write_done = 1'b1;
          @(negedge clock);
          m_write_done = 1'b0;
          op_log.push_back(1);
        end
      end
    end
  end

  initial begin
    logic [127:0] wdat;
    i_addr  = '0;
    d_addr  = '0;
    d_waddr = '0;
    d_wdata = '0;
    do_reset();

    // Reset state
    check("rst_grant", grant, 2'b00);
    check("rst_m_read", m_read, 1'b0);
    check("rst_m_write", m_write, 1'b0);
    check("rst_pulses", {i_valid, d_valid, d_wdone}, 3'b000);
    check("rst_i_rdata", i_rdata, 128'h0);
    check("rst_d_rdata", d_rdata, 128'h0);

    // Single icache fill, unaligned address
    snap();
    exp_rd(32'h0000_0104, {32{4'hA}}, 1'b1);
    run_i(32'h0000_0100, 1);
    repeat (3) @(negedge clock);
    check("i_fill_pulses", i_pulses - ip0, 1);
    eg = '{2'b01, 2'b00};
    check_grants("i_fill_grant", eg);

    // Simultaneous requests after reset: icache first
    do_reset();
    snap();
    exp_rd(32'h0000_0500, rnd_blk(), 1'b1);
    exp_rd(32'h0000_0600, rnd_blk(), 1'b0);
    fork
      run_i(32'h0000_0500, 1);
      run_dr(32'h0000_0600, 1);
    join
    repeat (3) @(negedge clock);
    eg = '{2'b01, 2'b00, 2'b10, 2'b00};
    check_grants("tie_grant", eg);
    check("tie_pulses", (i_pulses - ip0) * 10 + (d_pulses - dp0), 11);

    // Writeback then fill, unaligned addresses, wdata changed after grant
    snap();
    op_log.delete();
    wdat = rnd_blk();
    wr_q.push_back('{32'h0000_0040, wdat});
    exp_rd(32'h0000_0080, rnd_blk(), 1'b0);
    d_waddr = 32'h0000_004C;
    d_wdata = wdat;
    d_addr  = 32'h0000_0087;
    d_write = 1'b1;
    d_read  = 1'b1;
    @(negedge clock);
    d_wdata = ~wdat;
    d_waddr = 32'hDEAD_BEE0;
    wait_sig(2, "d_wdone_seen");
    d_write = 1'b0;
    wait_sig(1, "d_valid_seen");
    d_read = 1'b0;
    repeat (3) @(negedge clock);
    check("wb_wdone_pulses", wd_pulses - wp0, 1);
    check("wb_op_cnt", op_log.size(), 2);
    check("wb_op_order", {op_log[0][1:0], op_log[1][1:0]}, 4'b0110);
    eg = '{2'b10, 2'b00};
    check_grants("wb_grant", eg);

    // Continuous contention: strict alternation
    snap();
    for (int k = 0; k < 3; k++) begin
      exp_rd(32'h0000_1000 + 32'(k * 16), rnd_blk(), 1'b1);
      exp_rd(32'h0000_2000 + 32'(k * 16), rnd_blk(), 1'b0);
    end
    fork
      run_i(32'h0000_1000, 3);
      run_dr(32'h0000_2000, 3);
    join
    repeat (3) @(negedge clock);
    eg = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00,
           2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    check_grants("rr_grant", eg);

    // Reset two cycles into a dcache fill
    snap();
    rd_lat = 10;
    rd_q.push_back('{32'h0000_0200, rnd_blk()});
    d_addr = 32'h0000_0208;
    d_read = 1'b1;
    wait_sig(3, "dfill_started");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_m_read", m_read, 1'b0);
    check("mid_rst_grant", grant, 2'b00);
    check("mid_rst_d_rdata", d_rdata, 128'h0);
    check("mid_rst_i_rdata", i_rdata, 128'h0);
    reset  = 1'b0;
    d_read = 1'b0;
    repeat (15) @(negedge clock);
    check("mid_rst_no_d_valid", d_pulses - dp0, 0);
    rd_lat = 3;

    // Spurious memory responses while idle
    snap();
    m_read_data  = rnd_blk();
    m_read_valid = 1'b1;
    @(negedge clock);
    m_read_valid = 1'b0;
    m_write_done = 1'b1;
    @(negedge clock);
    m_write_done = 1'b0;
    repeat (3) @(negedge clock);
    check("spur_pulses", (i_pulses - ip0) + (d_pulses - dp0) + (wd_pulses - wp0), 0);
    check("spur_idle", {grant, m_read, m_write}, 4'b0000);

    // Request withdrawn mid-fill still completes from the latched address
    snap();
    exp_rd(32'h0000_0300, rnd_blk(), 1'b1);
    i_addr = 32'h0000_0308;
    i_read = 1'b1;
    wait_sig(3, "drop_started");
    i_read = 1'b0;
    i_addr = 32'hFFFF_FFF0;
    wait_sig(0, "drop_i_valid_seen");
    repeat (3) @(negedge clock);
    check("drop_pulses", i_pulses - ip0, 1);

    check("no_overlap", overlap_cnt, 0);
    check("rd_q_drained", rd_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule
